// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
//  Shared definitions for the data-memory arbiter: FSM state encodings,
//  requester identifiers and the wait-counter width helper.
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arbState_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } reqId_t;

    // Width needed to hold MEM_LAT-1 down to 0; never narrower than one bit.
    function automatic int cntWidth(input int memLat);
        return (memLat < 1) ? 1 : $clog2(memLat + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb_rr2.sv
// ----------------------------------------------------------------------------
// arb_rr2
//  Two-way round-robin grant. When both requesters are active the one that
//  did not win last time is granted. The last-grant register only moves on
//  an actual grant, and only while enabled (arbiter FSM in IDLE).
// Ports
//  clk, reset    system clock, synchronous active-high reset
//  enable        arbitration allowed this cycle
//  reqCpu/reqDbg request lines
//  grantValid    a grant is issued this cycle
//  grantId       winning requester (meaningful when grantValid)
// ----------------------------------------------------------------------------
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  logic   reqCpu,
    input  logic   reqDbg,
    output logic   grantValid,
    output reqId_t grantId
);

    reqId_t lastGrant;

    always_comb begin
        grantValid = enable & (reqCpu | reqDbg);
        if (reqCpu & reqDbg) begin
            grantId = (lastGrant == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (reqDbg) begin
            grantId = REQ_DBG;
        end else begin
            grantId = REQ_CPU;
        end
    end

    // Reset to DBG so the CPU wins the first contended grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant <= REQ_DBG;
        end else if (grantValid) begin
            lastGrant <= grantId;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//  Shares the single data-memory port between the CPU datapath and the
//  debug/boot-loader port. One transaction in flight, round-robin fairness,
//  fixed-latency memory (MEM_LAT cycles from mem_en to read data).
// Ports
//  clk, reset                 system clock, synchronous active-high reset
//  cpu_req/we/adr/wdata       CPU request, held until cpu_ack
//  cpu_rdata, cpu_ack         CPU load data and one-cycle completion pulse
//  dbg_*                      same handshake for the debug side
//  mem_en/we/adr/wdata        registered memory command, mem_en one cycle
//  mem_rdata                  memory read data, valid MEM_LAT after mem_en
//  cpu_stall                  freezes the CPU while its request is pending
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | arbitrate; latch winner's command and owner
//  ST_ACCESS | mem_en high for this single cycle
//  ST_WAIT   | read only: count MEM_LAT cycles, capture data on the last
//  ST_RESP   | owner's ack high for one cycle, rdata valid
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_adr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_stall
);

    localparam int CW = cntWidth(MEM_LAT);

    arbState_t     state;
    reqId_t        owner;
    logic [CW-1:0] waitCnt;
    logic          grantValid;
    reqId_t        grantId;

    arb_rr2 uArb (
        .clk       (clk),
        .reset     (reset),
        .enable    (state == ST_IDLE),
        .reqCpu    (cpu_req),
        .reqDbg    (dbg_req),
        .grantValid(grantValid),
        .grantId   (grantId)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= REQ_CPU;
            waitCnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle below.
            mem_en  <= 1'b0;
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grantValid) begin
                        owner     <= grantId;
                        mem_we    <= (grantId == REQ_DBG) ? dbg_we    : cpu_we;
                        mem_adr   <= (grantId == REQ_DBG) ? dbg_adr   : cpu_adr;
                        mem_wdata <= (grantId == REQ_DBG) ? dbg_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_we) begin
                        // Ack is registered, so raising it here lands it in RESP.
                        if (owner == REQ_DBG) dbg_ack <= 1'b1;
                        else                  cpu_ack <= 1'b1;
                        state <= ST_RESP;
                    end else begin
                        waitCnt <= CW'(MEM_LAT - 1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (waitCnt == '0) begin
                        if (owner == REQ_DBG) begin
                            dbg_rdata <= mem_rdata;
                            dbg_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        waitCnt <= waitCnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Held low during reset so a stale request cannot freeze the CPU.
    assign cpu_stall = cpu_req & ~cpu_ack & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_adr = '0, cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_adr = '0, dbg_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] cpu_rdata, dbg_rdata, mem_adr, mem_wdata;
    logic        cpu_ack, dbg_ack, mem_en, mem_we, cpu_stall;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    endtask

    // Transaction-level model: a request sampled in an idle cycle c yields
    // mem_en in c+1 and an ack in c+2 (write) or c+LAT+2 (read); the next
    // request can be sampled the cycle after the ack.
    bit          modelOk = 1'b0;
    int          memEnCyc = -100, ackCyc = -100, nextSample = 0;
    bit          ownDbg = 1'b0, mWe = 1'b0, lastDbg = 1'b1;
    logic [31:0] mAdr = '0;
    logic        eMemWe = 1'b0;
    logic [31:0] eMemAdr = '0, eMemWdata = '0, eCpuRd = '0, eDbgRd = '0;

    always @(posedge clk) begin
        int  c;
        bit  winDbg;
        c   = cyc;
        cyc = cyc + 1;
        if (reset) begin
            modelOk    = 1'b1;
            nextSample = cyc;
            memEnCyc   = -100;
            ackCyc     = -100;
            lastDbg    = 1'b1;
            eMemWe     = 1'b0;
            eMemAdr    = '0;
            eMemWdata  = '0;
            eCpuRd     = '0;
            eDbgRd     = '0;
        end else begin
            if (cyc == ackCyc && !mWe) begin
                if (ownDbg) eDbgRd = memData(mAdr);
                else        eCpuRd = memData(mAdr);
            end
            if (c >= nextSample && (cpu_req || dbg_req)) begin
                winDbg     = (cpu_req && dbg_req) ? !lastDbg : dbg_req;
                lastDbg    = winDbg;
                ownDbg     = winDbg;
                mWe        = winDbg ? dbg_we : cpu_we;
                mAdr       = winDbg ? dbg_adr : cpu_adr;
                eMemWe     = mWe;
                eMemAdr    = mAdr;
                eMemWdata  = winDbg ? dbg_wdata : cpu_wdata;
                memEnCyc   = cyc;
                ackCyc     = mWe ? cyc + 1 : cyc + LAT + 1;
                nextSample = ackCyc + 1;
            end
        end
    end

    // Per-cycle compare against the model, plus the memory responder.
    int          issueCyc = -100, memEnCount = 0, lastMemEnCyc = -100, cpuAckCount = 0;
    logic [31:0] issueAdr = '0, lastMemAdr = '0, lastMemWdata = '0;
    logic        lastMemWe = 1'b0;

    always @(negedge clk) begin
        logic expCpuAck, expDbgAck;
        expCpuAck = (cyc == ackCyc) && !ownDbg;
        expDbgAck = (cyc == ackCyc) && ownDbg;
        if (modelOk) begin
            check("mem_en",    {31'b0, mem_en},    {31'b0, cyc == memEnCyc});
            check("mem_we",    {31'b0, mem_we},    {31'b0, eMemWe});
            check("mem_adr",   mem_adr,            eMemAdr);
            check("mem_wdata", mem_wdata,          eMemWdata);
            check("cpu_ack",   {31'b0, cpu_ack},   {31'b0, expCpuAck});
            check("dbg_ack",   {31'b0, dbg_ack},   {31'b0, expDbgAck});
            check("cpu_rdata", cpu_rdata,          eCpuRd);
            check("dbg_rdata", dbg_rdata,          eDbgRd);
            check("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req & ~expCpuAck & ~reset});
        end
        if (cpu_ack === 1'b1) cpuAckCount++;
        if (mem_en === 1'b1) begin
            issueCyc     = cyc;
            issueAdr     = mem_adr;
            memEnCount++;
            lastMemEnCyc = cyc;
            lastMemAdr   = mem_adr;
            lastMemWe    = mem_we;
            lastMemWdata = mem_wdata;
        end
        mem_rdata = (cyc == issueCyc + LAT) ? memData(issueAdr) : (32'hBAD0_0000 | 32'(cyc));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitAck(input bit dbg, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((dbg ? dbg_ack : cpu_ack) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        nChecks++;
        if (at < 0) $display("FAIL %s_ack_timeout: no ack within %0d cycles, required one", dbg ? "dbg" : "cpu", limit);
        else nPass++;
    endtask

    task automatic waitAnyAck(input int limit, output int who, output int at);
        at  = -1;
        who = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1 || dbg_ack === 1'b1) begin
                at  = cyc;
                who = (dbg_ack === 1'b1) ? 1 : 0;
                break;
            end
        end
        nChecks++;
        if (at < 0) $display("FAIL any_ack_timeout: no ack within %0d cycles, required one", limit);
        else nPass++;
    endtask

    initial begin
        int t0, t1, at, at2, who, base;
        int order[4];
        int expOrder[4] = '{0, 1, 0, 1};

        // 1: reset with random request traffic
        repeat (2) begin
            cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_adr = $urandom;
            dbg_req = 1'($urandom); dbg_we = 1'($urandom); dbg_adr = $urandom;
            tick();
        end
        check("reset_no_mem_en", memEnCount, 0);
        check("reset_cpu_ack", {31'b0, cpu_ack}, 0);
        reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;

        // 2: CPU read of 0x40
        base = memEnCount;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h40; t0 = cyc;
        waitAck(1'b0, 20, at);
        check("t2_ack_latency", at - t0, 4);
        check("t2_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t2_mem_en_count", memEnCount - base, 1);
        check("t2_mem_adr", lastMemAdr, 32'h40);
        check("t2_mem_we", {31'b0, lastMemWe}, 0);
        tick();
        cpu_req = 1'b0;

        // 3: CPU write of 0x44
        tick();
        base = memEnCount;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h44; cpu_wdata = 32'h12345678; t0 = cyc;
        waitAck(1'b0, 20, at);
        check("t3_ack_latency", at - t0, 2);
        check("t3_rdata_kept", cpu_rdata, 32'hDEADBEEF);
        check("t3_mem_en_count", memEnCount - base, 1);
        check("t3_mem_we", {31'b0, lastMemWe}, 1);
        check("t3_mem_wdata", lastMemWdata, 32'h12345678);
        tick();
        cpu_req = 1'b0;

        // 4: both requesting after reset -> CPU, DBG, CPU, DBG
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h100;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h200; dbg_wdata = 32'hCAFE0001;
        for (int k = 0; k < 4; k++) begin
            waitAnyAck(20, who, at);
            order[k] = who;
        end
        tick();
        cpu_req = 1'b0; dbg_req = 1'b0;
        for (int k = 0; k < 4; k++) check($sformatf("t4_grant%0d", k), order[k], expOrder[k]);

        // 5: debug request arriving while a CPU read is in WAIT
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h48; t0 = cyc;
        tick();
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h84;
        waitAck(1'b0, 20, at);
        check("t5_cpu_latency", at - t0, 4);
        tick();
        cpu_req = 1'b0;
        waitAck(1'b1, 20, at2);
        check("t5_dbg_mem_en_cycle", lastMemEnCyc - at, 2);
        check("t5_dbg_ack_cycle", at2 - at, LAT + 3);
        check("t5_dbg_rdata", dbg_rdata, 32'h0084C0DE);
        tick();
        dbg_req = 1'b0;

        // 6: reset during WAIT of a CPU read, then a debug read of 0x80
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h4C; t0 = cyc;
        tick();
        tick();
        base = cpuAckCount;
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h80; t1 = cyc;
        waitAck(1'b1, 20, at);
        check("t6_dbg_latency", at - t1, LAT + 2);
        check("t6_dbg_rdata", dbg_rdata, 32'h0080C0DE);
        check("t6_no_cpu_ack", cpuAckCount - base, 0);
        tick();
        dbg_req = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

endmodule
